// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready handshake bundle for one side of a pipeline stage.
// master drives valid/ctrl/data and samples ready; slave is the reverse.
interface pipe_stage_skid_reg_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer.
// In.ready comes straight from a flop, so back-pressure never forms a
// combinational path across stages. Control bits read as zero whenever
// the output entry is not valid; datapath bits keep their last value.
// Optional feature macro: PIPE_STAGE_PERF_EN enables the saturating
// Stall_Cnt / Bubble_Cnt counters (tied to zero otherwise).
module pipe_stage_skid_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Flush,
  pipe_stage_skid_reg_if.slave  In,
  pipe_stage_skid_reg_if.master Out,
  output logic [CNT_WIDTH-1:0] Stall_Cnt,
  output logic [CNT_WIDTH-1:0] Bubble_Cnt
);

  // Encoding is {main_valid, skid_valid}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_LOAD_IN,
    MAIN_LOAD_SKID,
    MAIN_BUBBLE
  } main_op_t;

  state_t                state;
  state_t                next_state;
  logic                  in_ready_q;
  logic                  main_valid;
  logic                  skid_valid;
  logic                  in_fire;
  logic                  out_fire;
  main_op_t              main_op;
  logic                  skid_load;
  logic                  skid_clear;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] main_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;

  assign main_valid = state[1];
  assign skid_valid = state[0];
  assign in_fire    = In.valid & in_ready_q;
  assign out_fire   = main_valid & Out.ready;

  assign In.ready   = in_ready_q;
  assign Out.valid  = main_valid;
  assign Out.ctrl   = main_ctrl;
  assign Out.data   = main_data;

  // State register; ready is registered from the next skid occupancy.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= next_state;
      in_ready_q <= ~next_state[0];
    end
  end

  // Next-state: flush wins over every handshake.
  always_comb begin
    next_state = state;
    if (Flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) next_state = BUSY;
        BUSY: begin
          if (in_fire && !out_fire)      next_state = FULL;
          else if (!in_fire && out_fire) next_state = EMPTY;
        end
        // FULL, and the unreachable (0,1) encoding treated as FULL.
        default: if (out_fire) next_state = BUSY;
      endcase
    end
  end

  // Datapath steering for the main and skid entries.
  always_comb begin
    main_op    = MAIN_HOLD;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (Flush) begin
      main_op    = MAIN_BUBBLE;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: if (in_fire) main_op = MAIN_LOAD_IN;
        BUSY: begin
          if (in_fire && out_fire) main_op = MAIN_LOAD_IN;
          else if (in_fire)        skid_load = 1'b1;
          else if (out_fire)       main_op = MAIN_BUBBLE;
        end
        default: begin
          if (out_fire) begin
            main_op    = MAIN_LOAD_SKID;
            skid_clear = 1'b1;
          end
        end
      endcase
    end
  end

  // Payload registers; bubbles zero control only, data is never cleared.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      case (main_op)
        MAIN_LOAD_IN: begin
          main_ctrl <= In.ctrl;
          main_data <= In.data;
        end
        MAIN_LOAD_SKID: begin
          main_ctrl <= skid_ctrl;
          main_data <= skid_data;
        end
        MAIN_BUBBLE: main_ctrl <= '0;
        default: ;
      endcase
      if (skid_load) begin
        skid_ctrl <= In.ctrl;
        skid_data <= In.data;
      end else if (skid_clear) begin
        skid_ctrl <= '0;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] bubble_cnt;

  // Saturating stall/bubble counters, cleared by flush.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (Flush) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !Out.ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (!main_valid && Out.ready && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
    end
  end

  assign Stall_Cnt  = stall_cnt;
  assign Bubble_Cnt = bubble_cnt;
`else
  assign Stall_Cnt  = '0;
  assign Bubble_Cnt = '0;
`endif

endmodule
